fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Shares the single frame_buffer write port between the pixel producers: fill_drawer, line_drawer and symbol_drawer. It replaces the current OR-merge of their write buses with request/grant arbitration, so two writers can never collide. Arbitration is round-robin with burst ownership, and a hold input freezes all writes around a buffer swap. Output is registered, one beat per cycle.

Parameters:
REQUESTERS, 3, number of write requesters; index 0 = fill, 1 = line, 2 = symbol.
ADDR_WIDTH, 19, frame_buffer address width; equals $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS).
MAX_BURST, 64, maximum consecutive granted beats per owner while another requester waits; must be >= 1.

Ports:
clk  in  1  pixel clock (clk_25M175 at top level)
rst_n  in  1  synchronous reset, active low
hold  in  1  1 = grant nothing; current ownership is kept
req  in  REQUESTERS  per-requester write request; addr and data are valid while high
req_addr  in  REQUESTERS*ADDR_WIDTH  packed addresses; requester i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  REQUESTERS  per-requester pixel value
gnt  out  REQUESTERS  one-hot or zero, combinational; req[i] & gnt[i] = beat accepted this cycle
fb_write_enable  out  1  registered write strobe to frame_buffer
fb_write_addr  out  ADDR_WIDTH  registered write address
fb_write_data  out  1  registered write data
busy  out  1  1 while any requester owns the port

Behaviour:
- Reset: rst_n low at a clk edge clears the following: owner_valid=0, burst_cnt=0, rr_ptr=0, fb_write_enable=0, fb_write_addr=0, fb_write_data=0. busy=0 and gnt=0 during and after reset.
- Handshake:
  - A requester holds req_addr and req_data stable while req=1 and gnt=0.
  - A requester may drop req only after an accepted beat.
  - gnt[i] is never asserted unless req[i]=1.
- States:
  - IDLE (owner_valid=0).
  - OWN(owner, burst_cnt).
- IDLE behaviour:
  - If hold=0 and any req is set, pick the first requesting index at or after rr_ptr (circular).
  - Grant it in the same cycle and enter OWN with burst_cnt=1.
- OWN behaviour with hold=0 and req[owner]=1:
  - If another requester is waiting and burst_cnt==MAX_BURST: do not grant the owner; set rr_ptr=(owner+1) mod REQUESTERS and go to IDLE. This gives one dead cycle, accepted for simplicity.
  - Otherwise: grant the owner. burst_cnt increments, saturating at MAX_BURST. With no competitor present, the burst is unlimited.
- OWN behaviour with req[owner]=0:
  - Release ownership with no grant that cycle.
  - Set rr_ptr=(owner+1) mod REQUESTERS and go to IDLE.
- hold=1:
  - gnt=0 for every requester.
  - State, burst_cnt and rr_ptr are frozen.
  - A release (req[owner]=0) is still processed.
- Output stage:
  - On an accepted beat from requester i, the next cycle has fb_write_enable=1, fb_write_addr=req_addr[i], fb_write_data=req_data[i]. Latency is one cycle.
  - Otherwise fb_write_enable=0, and addr/data hold their previous values.
- busy = owner_valid.
- Reset mid-burst: ownership is dropped. A beat accepted in the reset cycle is discarded and never reaches frame_buffer.
- rr_ptr wraps from REQUESTERS-1 to 0.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits; rr_ptr is $clog2(REQUESTERS) bits. There are no arithmetic overflows.

Optional Feature:
FB_ARB_STATS_EN:
- When defined, adds output stat_beats (REQUESTERS*16 bits).
- stat_beats holds per-requester counts of accepted beats.
- Each 16-bit count saturates at 16'hFFFF and clears on reset.
- When undefined, the port and the counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fb_arb_pkg holds:
  - requester index constants REQ_FILL=0, REQ_LINE=1, REQ_SYMBOL=2;
  - REQUESTERS;
  - the ADDR_WIDTH derivation function.
- One sub-module: rr_pick. It is combinational and returns the first set bit of req at or after rr_ptr, as a one-hot plus a valid flag.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with req=3'b111 -> gnt=0, fb_write_enable=0, busy=0 throughout.
- Single requester: fill requests 5 beats at addr 0..4, data=1 -> gnt[0] high for 5 cycles; fb_write_enable high for 5 cycles, one cycle late; fb_write_addr 0..4 in order.
- Contention, MAX_BURST=4: fill and line both request continuously from reset -> fill gets 4 beats, 1 dead cycle, line gets 4 beats, 1 dead cycle, then fill again. The gnt pattern repeats every 10 cycles.
- Unlimited burst: symbol is the only requester for 100 beats with MAX_BURST=4 -> 100 consecutive grants, no gaps.
- Hold mid-burst: line owns the port and hold=1 for 3 cycles -> gnt=0 and fb_write_enable=0 for exactly those cycles (plus one cycle of output lag). Line resumes on the first hold=0 cycle, and burst_cnt continues from its prior value.
- Reset mid-burst: assert rst_n=0 on a cycle where gnt[1]=1 -> fb_write_enable=0 on the next cycle and busy=0. After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame_buffer write arbiter: requester indices,
// default requester count, arbiter states and the frame_buffer address width.
package fb_arb_pkg;

    localparam int REQUESTERS        = 3;
    localparam int HOR_ACTIVE_PIXELS = 640;
    localparam int VER_ACTIVE_PIXELS = 480;

    typedef enum int {
        REQ_FILL   = 0,
        REQ_LINE   = 1,
        REQ_SYMBOL = 2
    } req_idx_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic int fb_addr_width(input int hor, input int ver);
        return $clog2(hor * ver);
    endfunction

    localparam int FB_ADDR_WIDTH = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after i_ptr,
// searched circularly, returned as a one-hot vector plus a valid flag.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic             o_valid
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        o_onehot = '0;
        o_valid  = 1'b0;
        // Upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
                o_onehot[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (PTR_W'(i) < i_ptr)) begin
                o_onehot[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-owning arbiter for the single frame_buffer write port.
// Define FB_ARB_STATS_EN to add per-requester saturating accepted-beat counters.
module fb_write_arbiter #(
    parameter int REQUESTERS = fb_arb_pkg::REQUESTERS,
    parameter int ADDR_WIDTH = fb_arb_pkg::FB_ADDR_WIDTH,
    parameter int MAX_BURST  = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             hold,
    input  logic [REQUESTERS-1:0]            req,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [REQUESTERS-1:0]            req_data,
    output logic [REQUESTERS-1:0]            gnt,
    output logic                             fb_write_enable,
    output logic [ADDR_WIDTH-1:0]            fb_write_addr,
    output logic                             fb_write_data,
    output logic                             busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [REQUESTERS*16-1:0]         stat_beats
`endif
);
    import fb_arb_pkg::*;

    localparam int               PTR_W     = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(REQUESTERS - 1);

    arb_state_e            r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_owner, w_owner_nxt;
    logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]      r_burst_cnt, w_burst_cnt_nxt;
    logic [PTR_W-1:0]      w_pick_idx, w_owner_succ;
    logic [REQUESTERS-1:0] w_pick_oh, w_owner_oh, w_gnt;
    logic                  w_pick_valid, w_owner_req, w_competitor;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic                  w_acc_data, w_accept;

    rr_pick #(
        .N     (REQUESTERS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_owner_oh = '0;
        w_pick_idx = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_owner_oh[i] = (r_owner == PTR_W'(i));
            if (w_pick_oh[i]) w_pick_idx = PTR_W'(i);
        end
    end

    assign w_owner_req  = |(req & w_owner_oh);
    assign w_competitor = |(req & ~w_owner_oh);
    assign w_owner_succ = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_gnt           = '0;
        case (r_state)
            ST_IDLE: begin
                if (!hold && w_pick_valid) begin
                    w_gnt           = w_pick_oh;
                    w_state_nxt     = ST_OWN;
                    w_owner_nxt     = w_pick_idx;
                    w_burst_cnt_nxt = CNT_W'(1);
                end
            end
            ST_OWN: begin
                // A release is honoured even under hold; a burst cap only when not held.
                if (!w_owner_req || (!hold && w_competitor && (r_burst_cnt == BURST_MAX))) begin
                    w_state_nxt     = ST_IDLE;
                    w_rr_ptr_nxt    = w_owner_succ;
                    w_burst_cnt_nxt = '0;
                end else if (!hold) begin
                    w_gnt = w_owner_oh;
                    if (r_burst_cnt != BURST_MAX) w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gating on rst_n keeps gnt and busy low during reset, before state is known.
    assign gnt      = rst_n ? w_gnt : '0;
    assign busy     = rst_n && (r_state == ST_OWN);
    assign w_accept = |(gnt & req);

    always_comb begin
        w_acc_addr = '0;
        w_acc_data = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (gnt[i]) begin
                w_acc_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_acc_data = req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_write_enable <= 1'b0;
            fb_write_addr   <= '0;
            fb_write_data   <= 1'b0;
        end else begin
            fb_write_enable <= w_accept;
            if (w_accept) begin
                fb_write_addr <= w_acc_addr;
                fb_write_data <= w_acc_data;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_stat [REQUESTERS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REQUESTERS; i++) r_stat[i] <= '0;
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (gnt[i] && (r_stat[i] != 16'hFFFF)) r_stat[i] <= r_stat[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < REQUESTERS; i++) stat_beats[i*16 +: 16] = r_stat[i];
    end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed scoreboard bench for fb_write_arbiter with MAX_BURST=4: reset, single
// requester, contention, unlimited burst, hold mid-burst and reset mid-burst.
module tb_fb_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int MB = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_data;
    logic [N-1:0]    gnt;
    logic            fb_write_enable;
    logic [AW-1:0]   fb_write_addr;
    logic            fb_write_data;
    logic            busy;
`ifdef FB_ARB_STATS_EN
    logic [N*16-1:0] stat_beats;
`endif

    logic [AW-1:0] a [N];
    wr_t           sb [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    assign req_addr = {a[2], a[1], a[0]};

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .REQUESTERS (N),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hold            (hold),
        .req             (req),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .gnt             (gnt),
        .fb_write_enable (fb_write_enable),
        .fb_write_addr   (fb_write_addr),
        .fb_write_data   (fb_write_data),
        .busy            (busy)
`ifdef FB_ARB_STATS_EN
        ,
        .stat_beats      (stat_beats)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; compare at the falling edge,
    // pop the write expected from the previous cycle, push this cycle's beat.
    task automatic cycle(input logic [N-1:0] exp_gnt, input logic exp_busy, input string tag);
        wr_t e;
        @(negedge clk);
        check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, " busy"}, 32'(busy), 32'(exp_busy));
        check({tag, " we"}, 32'(fb_write_enable), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, " addr"}, 32'(fb_write_addr), 32'(e.addr));
            check({tag, " data"}, 32'(fb_write_data), 32'(e.data));
        end
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) sb.push_back('{addr: a[2'(i)], data: req_data[2'(i)]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        @(negedge clk);
        check("rst gnt", 32'(gnt), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] exp_g;

        // Reset held 3 cycles with every requester asserting.
        rst_n    = 1'b0;
        hold     = 1'b0;
        req      = 3'b111;
        req_data = 3'b111;
        a[0] = 19'd10; a[1] = 19'd20; a[2] = 19'd30;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset[%0d] gnt", c), 32'(gnt), 32'(0));
            check($sformatf("reset[%0d] busy", c), 32'(busy), 32'(0));
            check($sformatf("reset[%0d] we", c), 32'(fb_write_enable), 32'(0));
        end
        rst_n = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;

        // Single requester: fill writes addr 0..4 with data 1.
        req_data = 3'b001;
        req      = 3'b001;
        for (int k = 0; k < 5; k++) begin
            a[0] = AW'(k);
            cycle(3'b001, k != 0, $sformatf("single[%0d]", k));
        end
        req = '0;
        cycle(3'b000, 1'b1, "single_release");
        cycle(3'b000, 1'b0, "single_idle");
        check("single hold addr", 32'(fb_write_addr), 32'(4));
        check("single hold data", 32'(fb_write_data), 32'(1));

        // Contention fill vs line from reset: 4 beats, dead cycle, 4 beats, dead cycle.
        do_reset();
        a[0] = 19'd1000;
        a[1] = 19'd2000;
        req_data = 3'b001;
        req      = 3'b011;
        for (int c = 0; c < 20; c++) begin
            if ((c % 10) < 4)       exp_g = 3'b001;
            else if ((c % 10) == 4) exp_g = 3'b000;
            else if ((c % 10) < 9)  exp_g = 3'b010;
            else                    exp_g = 3'b000;
            cycle(exp_g, (c % 5) != 0, $sformatf("contend[%0d]", c));
            if (exp_g[0]) a[0] = a[0] + 1'b1;
            if (exp_g[1]) a[1] = a[1] + 1'b1;
        end
        req = '0;
        cycle(3'b000, 1'b0, "contend_idle");

        // Symbol alone for 100 beats: no burst cap without a competitor.
        req = 3'b100;
        for (int k = 0; k < 100; k++) begin
            a[2]     = AW'(5000 + k);
            req_data = {k[0], 2'b00};
            cycle(3'b100, k != 0, $sformatf("unlim[%0d]", k));
        end
        req = '0;
        cycle(3'b000, 1'b1, "unlim_release");
        cycle(3'b000, 1'b0, "unlim_idle");

        // Hold mid-burst: line takes 2 beats, 3 held cycles, 2 more beats, then capped.
        a[0] = 19'd8000;
        a[1] = 19'd7000;
        req_data = 3'b010;
        req      = 3'b010;
        cycle(3'b010, 1'b0, "hold_c0"); a[1] = a[1] + 1'b1;
        cycle(3'b010, 1'b1, "hold_c1"); a[1] = a[1] + 1'b1;
        hold = 1'b1;
        req  = 3'b011;
        cycle(3'b000, 1'b1, "hold_c2");
        cycle(3'b000, 1'b1, "hold_c3");
        cycle(3'b000, 1'b1, "hold_c4");
        hold = 1'b0;
        cycle(3'b010, 1'b1, "hold_c5"); a[1] = a[1] + 1'b1;
        cycle(3'b010, 1'b1, "hold_c6"); a[1] = a[1] + 1'b1;
        cycle(3'b000, 1'b1, "hold_c7_cap");
        cycle(3'b001, 1'b0, "hold_c8");  a[0] = a[0] + 1'b1;
        req = 3'b010;
        cycle(3'b000, 1'b1, "hold_c9");
        cycle(3'b010, 1'b0, "hold_c10"); a[1] = a[1] + 1'b1;
        req = '0;
        cycle(3'b000, 1'b1, "hold_c11");
        cycle(3'b000, 1'b0, "hold_c12");

        // Reset while line is granted; arbitration restarts at index 0.
        a[1] = 19'd9000;
        req_data = 3'b010;
        req      = 3'b010;
        cycle(3'b010, 1'b0, "rstmid_c0"); a[1] = a[1] + 1'b1;
        cycle(3'b010, 1'b1, "rstmid_c1"); a[1] = a[1] + 1'b1;
        rst_n = 1'b0;
        cycle(3'b000, 1'b0, "rstmid_c2");
        rst_n    = 1'b1;
        a[0]     = 19'd9500;
        req_data = 3'b011;
        req      = 3'b011;
        cycle(3'b001, 1'b0, "rstmid_c3"); a[0] = a[0] + 1'b1;
        cycle(3'b001, 1'b1, "rstmid_c4"); a[0] = a[0] + 1'b1;
        req = '0;
        cycle(3'b000, 1'b1, "rstmid_c5");
        cycle(3'b000, 1'b0, "rstmid_c6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
